// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS32 coprocessor-0 register file.
// Holds Status/Cause/EPC/BadVAddr and the Count/Compare timer, services MTC0/MFC0,
// and applies exception entry / ERET updates supplied by the exception unit.
module cp0_regfile #(
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [4:0]  raddr,
    input  logic [31:0] wdata,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype,
    input  logic [31:0] pc,
    input  logic        is_in_delayslot,
    input  logic [31:0] badramaddr,
    output logic [31:0] rdata,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    logic [31:0] status_q,   status_d;
    logic [31:0] cause_q,    cause_d;
    logic [31:0] epc_q,      epc_d;
    logic [31:0] count_q,    count_d;
    logic [31:0] compare_q,  compare_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        timer_int_q, timer_int_d;
    logic        tick_q,      tick_d;

    logic        exc_entry;
    logic        exc_eret;
    logic        exc_addr;
    logic [4:0]  exc_code;

    // Decode the exception-unit code into entry/ERET strobes and the Cause.ExcCode value.
    always_comb begin
        exc_entry = 1'b1;
        exc_addr  = 1'b0;
        exc_code  = 5'h00;
        case (excepttype)
            32'h0000_0001: exc_code = 5'h00;
            32'h0000_0004: begin exc_code = 5'h04; exc_addr = 1'b1; end
            32'h0000_0005: begin exc_code = 5'h05; exc_addr = 1'b1; end
            32'h0000_0008: exc_code = 5'h08;
            32'h0000_0009: exc_code = 5'h09;
            32'h0000_000a: exc_code = 5'h0a;
            32'h0000_000c: exc_code = 5'h0c;
            default:       exc_entry = 1'b0;
        endcase
        exc_eret = (excepttype == EXC_ERET);
    end

    // Next-state: timer, MTC0 writes, then exception/ERET updates which override MTC0.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        status_d    = status_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        compare_d   = compare_q;
        badvaddr_d  = badvaddr_q;
        timer_int_d = timer_int_q;
        tick_d      = ~tick_q;
        count_d     = tick_q ? count_q + 32'd1 : count_q;

        if (we) begin
            case (waddr)
                REG_COUNT: begin
                    count_d = wdata;
                    tick_d  = 1'b0;
                end
                REG_COMPARE: compare_d = wdata;
                REG_STATUS: begin
                    status_d[15:8] = wdata[15:8];
                    status_d[1:0]  = wdata[1:0];
                end
                REG_CAUSE:   cause_d[9:8] = wdata[9:8];
                REG_EPC:     epc_d = wdata;
                default: ;
            endcase
        end

        // Sticky timer match against the value Count is about to take; a Compare write clears it.
        if ((compare_q != 32'd0) && (count_d == compare_q)) begin
            timer_int_d = 1'b1;
        end
        if (we && (waddr == REG_COMPARE)) begin
            timer_int_d = 1'b0;
        end

        if (exc_entry) begin
            // A nested exception (EXL already set) must not clobber the original return point.
            if (!status_q[1]) begin
                epc_d     = is_in_delayslot ? pc - 32'd4 : pc;
                cause_d[31] = is_in_delayslot;
            end
            status_d[1]   = 1'b1;
            cause_d[6:2]  = exc_code;
            if (exc_addr) begin
                badvaddr_d = badramaddr;
            end
        end else if (exc_eret) begin
            status_d[1] = 1'b0;
        end

        // Hardware interrupt pending bits track the lines every cycle; timer shares IP7.
        cause_d[15:10] = {int_i[5] | timer_int_q, int_i[4:0]};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q    <= STATUS_RST;
            cause_q     <= 32'd0;
            epc_q       <= 32'd0;
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            badvaddr_q  <= 32'd0;
            timer_int_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge _d values together.
            status_q    <= status_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            badvaddr_q  <= badvaddr_d;
            timer_int_q <= timer_int_d;
            tick_q      <= tick_d;
        end
    end

    // MFC0 read mux from registered state; no bypass of a same-cycle write.
    always_comb begin
        rdata = 32'd0;
        case (raddr)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count_q;
            REG_COMPARE:  rdata = compare_q;
            REG_STATUS:   rdata = status_q;
            REG_CAUSE:    rdata = cause_q;
            REG_EPC:      rdata = epc_q;
            REG_PRID:     rdata = PRID_VAL;
            REG_CONFIG:   rdata = CONFIG_VAL;
            default:      rdata = 32'd0;
        endcase
    end

    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign badvaddr_o  = badvaddr_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed vector table, hand sequences for the
// timer and Count wrap, and randomized traffic against a field-level reference model.
module tb_cp0_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [4:0]  raddr;
    logic [31:0] wdata;
    logic [5:0]  int_i;
    logic [31:0] excepttype;
    logic [31:0] pc;
    logic        is_in_delayslot;
    logic [31:0] badramaddr;
    logic [31:0] rdata;
    logic [31:0] status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
    logic        timer_int_o;

    int n_checks = 0;
    int n_errors = 0;

    cp0_regfile dut (
        .clk            (clk),
        .rst            (rst),
        .we             (we),
        .waddr          (waddr),
        .raddr          (raddr),
        .wdata          (wdata),
        .int_i          (int_i),
        .excepttype     (excepttype),
        .pc             (pc),
        .is_in_delayslot(is_in_delayslot),
        .badramaddr     (badramaddr),
        .rdata          (rdata),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .count_o        (count_o),
        .compare_o      (compare_o),
        .badvaddr_o     (badvaddr_o),
        .timer_int_o    (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (field level) ----------------
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd;
    logic [4:0]  m_exc;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw;
    logic [31:0] m_epc, m_badv, m_cmp, m_cbase;
    int          m_ncyc;   // edges since Count was last loaded or reset
    logic        m_timer;

    function automatic logic [31:0] m_status_w();
        return {16'h0040, m_im, 6'b0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause_w();
        return {m_bd, 15'b0, m_iphw, m_ipsw, 1'b0, m_exc, 2'b0};
    endfunction

    // Count advances once per two edges after a load.
    function automatic logic [31:0] m_count_w();
        return m_cbase + 32'(m_ncyc / 2);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count_w();
            5'd11:   return m_cmp;
            5'd12:   return m_status_w();
            5'd13:   return m_cause_w();
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_4220;
            5'd16:   return 32'h0000_8000;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [7:0]  n_im;
        logic        n_exl, n_ie, n_bd, n_timer, is_exc;
        logic [4:0]  n_exc;
        logic [1:0]  n_ipsw;
        logic [31:0] n_epc, n_badv, n_cmp, n_cbase, n_count;
        int          n_ncyc;
        if (rst) begin
            m_im = '0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_exc = '0;
            m_ipsw = '0; m_iphw = '0; m_epc = '0; m_badv = '0; m_cmp = '0;
            m_cbase = '0; m_ncyc = 0; m_timer = 1'b0;
            return;
        end
        n_im = m_im; n_exl = m_exl; n_ie = m_ie; n_bd = m_bd; n_exc = m_exc;
        n_ipsw = m_ipsw; n_epc = m_epc; n_badv = m_badv; n_cmp = m_cmp;
        if (we && waddr == 5'd9) begin
            n_cbase = wdata; n_ncyc = 0;
        end else begin
            n_cbase = m_cbase; n_ncyc = m_ncyc + 1;
        end
        n_count = n_cbase + 32'(n_ncyc / 2);
        n_timer = m_timer | ((m_cmp != 0) && (n_count == m_cmp));
        if (we && waddr == 5'd11) begin
            n_timer = 1'b0; n_cmp = wdata;
        end
        if (we && waddr == 5'd12) begin
            n_im = wdata[15:8]; n_exl = wdata[1]; n_ie = wdata[0];
        end
        if (we && waddr == 5'd13) n_ipsw = wdata[9:8];
        if (we && waddr == 5'd14) n_epc = wdata;
        is_exc = excepttype inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc};
        if (is_exc) begin
            if (!m_exl) begin
                n_epc = is_in_delayslot ? pc - 32'd4 : pc;
                n_bd  = is_in_delayslot;
            end
            n_exl = 1'b1;
            n_exc = (excepttype == 32'h1) ? 5'h00 : excepttype[4:0];
            if (excepttype == 32'h4 || excepttype == 32'h5) n_badv = badramaddr;
        end else if (excepttype == 32'he) begin
            n_exl = 1'b0;
        end
        m_iphw = {int_i[5] | m_timer, int_i[4:0]};
        m_im = n_im; m_exl = n_exl; m_ie = n_ie; m_bd = n_bd; m_exc = n_exc;
        m_ipsw = n_ipsw; m_epc = n_epc; m_badv = n_badv; m_cmp = n_cmp;
        m_cbase = n_cbase; m_ncyc = n_ncyc; m_timer = n_timer;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [31:0] ex, input logic [31:0] p,
                         input logic sl, input logic [31:0] ba);
        we = w; waddr = wa; wdata = wd; raddr = ra; excepttype = ex;
        pc = p; is_in_delayslot = sl; badramaddr = ba;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic compare_all();
        check("rnd_status",   status_o,           m_status_w());
        check("rnd_cause",    cause_o,            m_cause_w());
        check("rnd_epc",      epc_o,              m_epc);
        check("rnd_count",    count_o,            m_count_w());
        check("rnd_compare",  compare_o,          m_cmp);
        check("rnd_badvaddr", badvaddr_o,         m_badv);
        check("rnd_timer",    {31'd0, timer_int_o}, {31'd0, m_timer});
        check("rnd_rdata",    rdata,              m_read(raddr));
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(); int_i = 6'd0;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exc;
        logic [31:0] pc;
        logic        slot;
        logic [31:0] bad;
        logic [31:0] e_status;
        logic [31:0] e_cause;
        logic [31:0] e_epc;
        logic [31:0] e_badv;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[12];

    localparam logic [4:0] RADDR_POOL [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};
    localparam logic [31:0] EXC_POOL [10] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9,
                                              32'ha, 32'hc, 32'he, 32'h3, 32'h20};

    initial begin
        // One row per cycle from reset with int_i=0 and Compare=0; expectations are post-edge.
        //          we    waddr  wdata          raddr  exc     pc             slot  bad             status         cause          epc            badv           rdata
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd8,  32'h4, 32'hBFC00100, 1'b0, 32'h00000003,   32'h00400002, 32'h00000010, 32'hBFC00100, 32'h00000003, 32'h00000003};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd12, 32'he, 32'h0,        1'b0, 32'h0,          32'h00400000, 32'h00000010, 32'hBFC00100, 32'h00000003, 32'h00400000};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd14, 32'hc, 32'hBFC00204, 1'b1, 32'h0,          32'h00400002, 32'h80000030, 32'hBFC00200, 32'h00000003, 32'hBFC00200};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd13, 32'h8, 32'h12345678, 1'b0, 32'h0,          32'h00400002, 32'h80000020, 32'hBFC00200, 32'h00000003, 32'h80000020};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd15, 32'he, 32'h0,        1'b0, 32'h0,          32'h00400000, 32'h80000020, 32'hBFC00200, 32'h00000003, 32'h00004220};
        vecs[5]  = '{1'b1, 5'd12, 32'h0000FF03, 5'd12, 32'h8, 32'h00000400, 1'b0, 32'h0,          32'h0040FF03, 32'h00000020, 32'h00000400, 32'h00000003, 32'h0040FF03};
        vecs[6]  = '{1'b1, 5'd15, 32'hFFFFFFFF, 5'd16, 32'h0, 32'h0,        1'b0, 32'h0,          32'h0040FF03, 32'h00000020, 32'h00000400, 32'h00000003, 32'h00008000};
        vecs[7]  = '{1'b1, 5'd13, 32'hFFFFFFFF, 5'd3,  32'h0, 32'h0,        1'b0, 32'h0,          32'h0040FF03, 32'h00000320, 32'h00000400, 32'h00000003, 32'h00000000};
        vecs[8]  = '{1'b1, 5'd14, 32'hDEADBEEF, 5'd14, 32'h1, 32'h00000800, 1'b1, 32'h0,          32'h0040FF03, 32'h00000300, 32'hDEADBEEF, 32'h00000003, 32'hDEADBEEF};
        vecs[9]  = '{1'b1, 5'd8,  32'h0,        5'd8,  32'h5, 32'h0,        1'b0, 32'hCAFE0001,   32'h0040FF03, 32'h00000314, 32'hDEADBEEF, 32'hCAFE0001, 32'hCAFE0001};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd13, 32'h3, 32'h0,        1'b0, 32'h0,          32'h0040FF03, 32'h00000314, 32'hDEADBEEF, 32'hCAFE0001, 32'h00000314};
        vecs[11] = '{1'b1, 5'd12, 32'h0,        5'd12, 32'he, 32'h0,        1'b0, 32'h0,          32'h00400000, 32'h00000314, 32'hDEADBEEF, 32'hCAFE0001, 32'h00400000};

        rst = 1'b1;
        int_i = 6'd0;
        idle();

        // Reset state.
        cycle(); cycle();
        check("rst_status",   status_o,   32'h00400000);
        check("rst_cause",    cause_o,    32'h0);
        check("rst_epc",      epc_o,      32'h0);
        check("rst_count",    count_o,    32'h0);
        check("rst_compare",  compare_o,  32'h0);
        check("rst_badvaddr", badvaddr_o, 32'h0);
        check("rst_timer",    {31'd0, timer_int_o}, 32'h0);
        rst = 1'b0;

        // Count runs at half clock rate.
        for (int i = 0; i < 10; i++) cycle();
        check("count_half_rate", count_o, 32'd5);

        // Timer: Compare=3, wait for the match, then clear with a new Compare.
        do_reset();
        drive(1'b1, 5'd11, 32'd3, 5'd11, 32'd0, 32'd0, 1'b0, 32'd0);
        cycle();
        idle();
        for (int i = 0; i < 40 && !timer_int_o; i++) cycle();
        check("timer_set",       {31'd0, timer_int_o}, 32'd1);
        check("timer_set_count", count_o, 32'd3);
        cycle();
        check("timer_cause_ip7", {31'd0, cause_o[15]}, 32'd1);
        drive(1'b1, 5'd11, 32'd10, 5'd11, 32'd0, 32'd0, 1'b0, 32'd0);
        cycle();
        idle();
        check("timer_clear", {31'd0, timer_int_o}, 32'd0);

        // Count wraps: load FFFFFFFF, holds one edge, then rolls to 0.
        drive(1'b1, 5'd9, 32'hFFFFFFFF, 5'd9, 32'd0, 32'd0, 1'b0, 32'd0);
        cycle();
        idle();
        raddr = 5'd9;
        check("wrap_load", count_o, 32'hFFFFFFFF);
        cycle();
        check("wrap_hold", count_o, 32'hFFFFFFFF);
        cycle();
        check("wrap_zero", count_o, 32'h0);
        check("wrap_rdata", rdata, 32'h0);

        // Directed vector table.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr,
                  vecs[i].exc, vecs[i].pc, vecs[i].slot, vecs[i].bad);
            cycle();
            check($sformatf("vec%0d_status", i), status_o,   vecs[i].e_status);
            check($sformatf("vec%0d_cause", i),  cause_o,    vecs[i].e_cause);
            check($sformatf("vec%0d_epc", i),    epc_o,      vecs[i].e_epc);
            check($sformatf("vec%0d_badv", i),   badvaddr_o, vecs[i].e_badv);
            check($sformatf("vec%0d_rdata", i),  rdata,      vecs[i].e_rdata);
        end

        // Reset asserted alongside a write and an exception wins outright.
        drive(1'b1, 5'd12, 32'h0000FF03, 5'd12, 32'h4, 32'h11110000, 1'b0, 32'h22220000);
        int_i = 6'h3F;
        rst = 1'b1;
        cycle();
        check("midrst_status", status_o,   32'h00400000);
        check("midrst_cause",  cause_o,    32'h0);
        check("midrst_epc",    epc_o,      32'h0);
        check("midrst_badv",   badvaddr_o, 32'h0);
        check("midrst_count",  count_o,    32'h0);
        rst = 1'b0;
        idle();
        int_i = 6'd0;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            rst = ($urandom_range(0, 299) == 0);
            we  = ($urandom_range(0, 2) == 0);
            waddr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : RADDR_POOL[$urandom_range(0, 7)];
            raddr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : RADDR_POOL[$urandom_range(0, 7)];
            wdata = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
            r = $urandom_range(0, 15);
            excepttype = (r < 6) ? 32'd0 : EXC_POOL[r - 6];
            pc = {$urandom} & 32'hFFFF_FFFC;
            is_in_delayslot = 1'($urandom);
            badramaddr = $urandom;
            int_i = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            cycle();
            compare_all();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
